man_tx_ctrl: RTL and testbench
==============================

MAN_TX_CTRL -- requirements
Module: man_tx_ctrl

Interface
REQ-001 SHALL have parameter ETU_CLKS, default 32, meaning clk cycles per ETU (106 kb/s at fc/4); legal values are even and >= 4.
REQ-002 SHALL have port clk, input, 1 bit: single clock, fc/4 (3.39 MHz); all logic on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port tx_start, input, 1 bit: frame start request, sampled only in IDLE.
REQ-005 SHALL have port in_valid, input, 1 bit: in_byte/in_last are valid.
REQ-006 SHALL have port in_byte, input, 8 bits: next frame byte, sent LSB first.
REQ-007 SHALL have port in_last, input, 1 bit: the byte is the final byte of the frame.
REQ-008 SHALL have port in_ready, output, 1 bit: byte accepted in any cycle where in_valid && in_ready.
REQ-009 SHALL have port man_enable, output, 1 bit: drives the in_enable input of the Manchester encoder.
REQ-010 SHALL have port man_data, output, 1 bit: drives the in_data input of the Manchester encoder.
REQ-011 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on normal frame completion.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse on underrun abort.

Function
REQ-014 SHALL implement an FSM with states IDLE, SOF, DATA, PARITY, EOF.
REQ-015 SHALL hold every transmitted bit (SOF, data, parity) on man_data for exactly ETU_CLKS cycles, using an ETU counter of width $clog2(ETU_CLKS) that wraps at ETU_CLKS-1.
REQ-016 IDLE: when tx_start=1, SHALL enter SOF in the next cycle with the ETU counter at 0; when tx_start=0, SHALL remain in IDLE.
REQ-017 SOF: SHALL drive man_enable=1 and man_data=1 for one ETU.
REQ-018 in_ready SHALL be high only in the final cycle of the SOF ETU and in the final cycle of a PARITY ETU whose byte had in_last=0; it SHALL be 0 in every other cycle.
REQ-019 SHALL, when a byte is accepted, latch in_byte and in_last, then enter DATA with the bit index at 0.
REQ-020 SHALL, when in_ready=1 and in_valid=0 (underrun), drive man_enable=0 and man_data=0 in the next cycle, pulse err for one cycle, and return to IDLE without pulsing done.
REQ-021 DATA: SHALL send bit[index] for index 0..7 with man_enable=1, and enter PARITY after index 7.
REQ-022 PARITY: SHALL send the odd-parity bit (~^byte), so that the total count of ones over data plus parity is odd, with man_enable=1.
REQ-023 after a PARITY ETU, SHALL go to DATA if a new byte was accepted, or to EOF if the latched in_last=1.
REQ-024 EOF: SHALL drive man_enable=0 and man_data=0 for one ETU, then return to IDLE, and SHALL pulse done in the first IDLE cycle.
REQ-025 busy SHALL be 1 in SOF, DATA, PARITY and EOF, and 0 in IDLE, including in the done and err pulse cycles.
REQ-026 man_data SHALL change only at ETU boundaries; man_enable SHALL be 0 in IDLE and EOF.
REQ-027 SHALL ignore tx_start while busy=1, and SHALL ignore in_valid outside in_ready cycles.
REQ-028 SHALL make done and err mutually exclusive and never both asserted.

Reset
REQ-029 On rst=1, including mid-frame, SHALL in the next cycle set state=IDLE, counters=0, and in_ready, man_enable, man_data, busy, done and err all = 0.
REQ-030 SHALL not pulse done or err as a result of a reset abort.
REQ-031 SHALL give rst priority over tx_start when both are asserted in the same cycle.

Verification
REQ-032 Single byte 0x26 with in_last=1, tx_start at cycle 0 -> man_enable=1 for cycles 1-320, bits 1,0,1,1,0,0,1,0,0,0 each 32 cycles; EOF for cycles 321-352; done pulse and busy=0 at cycle 353.
REQ-033 Two bytes 0x93 then 0x20 (last) -> data bits 1,1,0,0,1,0,0,1 with parity 1, then 0,0,0,0,0,1,0,0 with parity 0; man_enable high for 608 cycles; exactly two in_ready handshakes.
REQ-034 in_valid low at the end of the first PARITY ETU with in_last=0 -> err pulse, man_enable=0 the next cycle, no done, IDLE.
REQ-035 rst asserted at cycle 100 of a frame -> all outputs 0 at cycle 101; a subsequent tx_start produces a correct full frame.
REQ-036 tx_start pulsed at cycle 50 of a frame -> no effect; frame timing is identical to REQ-032.
REQ-037 ETU_CLKS=8 with byte 0x00 (last) -> parity 1, each bit held 8 cycles, man_enable high for 80 cycles.

Source files
------------

// File: rtl/man_tx_ctrl.sv
// Frame sequencer feeding a Manchester encoder: SOF, bytes LSB-first each
// followed by an odd-parity bit, then EOF. Every bit is held for one ETU.
module man_tx_ctrl #(
  parameter int ETU_CLKS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  input  logic       in_last,
  output logic       in_ready,
  output logic       man_enable,
  output logic       man_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = (ETU_CLKS > 1) ? $clog2(ETU_CLKS) : 1;
  localparam logic [CW-1:0] ETU_LAST = CW'(ETU_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SOF    = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_EOF    = 3'd4
  } state_t;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   etu_q, etu_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      byte_q, byte_d;
  logic            last_q, last_d;
  logic            in_ready_q, in_ready_d;
  logic            man_enable_q, man_enable_d;
  logic            man_data_q, man_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            etu_end_s;
  logic            accept_s;

  assign etu_end_s = (etu_q == ETU_LAST);
  // in_ready_q is already the handshake qualifier for the current cycle
  assign accept_s  = in_ready_q & in_valid;

  // Next-state logic, plus outputs decoded from the next state so they leave flops
  always_comb begin
    state_d = state_q;
    etu_d   = etu_end_s ? '0 : etu_q + 1'b1;
    idx_d   = idx_q;
    byte_d  = byte_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        etu_d = '0;
        idx_d = 3'd0;
        if (tx_start) begin
          state_d = S_SOF;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SOF, S_PARITY: begin
        if (!etu_end_s) begin
          state_d = state_q;
        end else if (state_q == S_PARITY && last_q) begin
          state_d = S_EOF;
        end else if (accept_s) begin
          state_d = S_DATA;
          byte_d  = in_byte;
          last_d  = in_last;
          idx_d   = 3'd0;
        end else begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_DATA: begin
        if (!etu_end_s) begin
          state_d = S_DATA;
        end else if (idx_q == 3'd7) begin
          state_d = S_PARITY;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_EOF: begin
        if (etu_end_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_EOF;
        end
      end
      default: begin
        state_d = S_IDLE;
        etu_d   = '0;
      end
    endcase

    if (state_d == S_IDLE) begin
      etu_d = '0;
    end else begin
      etu_d = etu_d;
    end

    busy_d       = (state_d != S_IDLE);
    man_enable_d = (state_d inside {S_SOF, S_DATA, S_PARITY});
    case (state_d)
      S_SOF:    man_data_d = 1'b1;
      S_DATA:   man_data_d = byte_d[idx_d];
      S_PARITY: man_data_d = odd_parity(byte_d);
      default:  man_data_d = 1'b0;
    endcase
    in_ready_d = (etu_d == ETU_LAST) &&
                 ((state_d == S_SOF) || (state_d == S_PARITY && !last_d));
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      etu_q        <= '0;
      idx_q        <= 3'd0;
      byte_q       <= 8'd0;
      last_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      man_enable_q <= 1'b0;
      man_data_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      etu_q        <= etu_d;
      idx_q        <= idx_d;
      byte_q       <= byte_d;
      last_q       <= last_d;
      in_ready_q   <= in_ready_d;
      man_enable_q <= man_enable_d;
      man_data_q   <= man_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign man_enable = man_enable_q;
  assign man_data   = man_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_man_tx_ctrl.sv
// Scoreboard bench for man_tx_ctrl: per-ETU expectations are queued when a
// frame is loaded and checked cycle by cycle as the DUT transmits.
module tb_man_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tx_start, in_valid, in_last;
  logic [7:0] in_byte;
  logic rdy32, en32, dat32, busy32, done32, err32;
  logic rdy8, en8, dat8, busy8, done8, err8;

  man_tx_ctrl #(.ETU_CLKS(32)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .in_valid(in_valid),
    .in_byte(in_byte), .in_last(in_last), .in_ready(rdy32),
    .man_enable(en32), .man_data(dat32), .busy(busy32), .done(done32), .err(err32)
  );

  man_tx_ctrl #(.ETU_CLKS(8)) dut8 (
    .clk(clk), .rst(rst), .tx_start(tx_start), .in_valid(in_valid),
    .in_byte(in_byte), .in_last(in_last), .in_ready(rdy8),
    .man_enable(en8), .man_data(dat8), .busy(busy8), .done(done8), .err(err8)
  );

  typedef struct packed {
    logic en;
    logic dat;
    logic rdy;
    logic t_done;
    logic t_err;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] src_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit sel8     = 1'b0;
  int etu      = 32;

  // {man_enable, man_data, busy, done, err, in_ready} of the selected DUT
  function automatic logic [5:0] obs();
    if (sel8) return {en8, dat8, busy8, done8, err8, rdy8};
    else      return {en32, dat32, busy32, done32, err32, rdy32};
  endfunction

  function automatic exp_t mk(input logic en, dat, rdy, td, te);
    exp_t e;
    e.en = en; e.dat = dat; e.rdy = rdy; e.t_done = td; e.t_err = te;
    return e;
  endfunction

  task automatic load_frame(input logic [7:0] b [0:3], input int n, input bit final_last);
    int ones;
    logic lastb;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < n; i++) begin
      lastb = (i == n - 1) ? final_last : 1'b0;
      src_q.push_back({lastb, b[i]});
      ones = 0;
      for (int j = 0; j < 8; j++) begin
        exp_q.push_back(mk(1'b1, b[i][j], 1'b0, 1'b0, 1'b0));
        ones += int'(b[i][j]);
      end
      exp_q.push_back(mk(1'b1, (ones % 2 == 0), !lastb, 1'b0, 1'b0));
    end
    if (n > 0 && final_last) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    end else begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tx_start = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    src_q.delete();
  endtask

  task automatic run_frame(input int spur_at, output int en_cycles, output int hs);
    exp_t e;
    int cyc;
    logic [5:0] got, want;
    en_cycles = 0; hs = 0;
    @(negedge clk);
    tx_start = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    cyc = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.t_done || e.t_err) begin
        @(negedge clk);
        tx_start = 1'b0; in_valid = 1'b0;
        got  = obs();
        want = {3'b000, e.t_done, e.t_err, 1'b0};
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL frame_end cyc=%0d got=%b want=%b", cyc, got, want);
        end
      end else begin
        for (int c = 0; c < etu; c++) begin
          @(negedge clk);
          tx_start = (cyc == spur_at);
          got  = obs();
          want = {e.en, e.dat, 1'b1, 1'b0, 1'b0, e.rdy && (c == etu - 1)};
          n_checks++;
          if (got !== want) begin
            n_fail++;
            $display("FAIL frame_bit cyc=%0d got=%b want=%b", cyc, got, want);
          end
          if (got[5]) en_cycles++;
          if (got[0]) begin
            if (src_q.size() > 0) begin
              {in_last, in_byte} = src_q.pop_front();
              in_valid = 1'b1;
              hs++;
            end else begin
              in_valid = 1'b0;
            end
          end else begin
            in_valid = 1'($urandom_range(0, 1));
            in_byte  = 8'($urandom);
            in_last  = 1'($urandom_range(0, 1));
          end
          @(posedge clk);
          cyc++;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_counts(input string name, input int en_got, en_want, hs_got, hs_want);
    n_checks++;
    if (en_got != en_want || hs_got != hs_want) begin
      n_fail++;
      $display("FAIL %s enable_cycles=%0d want=%0d handshakes=%0d want=%0d",
               name, en_got, en_want, hs_got, hs_want);
    end
  endtask

  task automatic test_reset();
    logic [11:0] got;
    @(negedge clk);
    rst = 1'b1; tx_start = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    got = {en32, dat32, busy32, done32, err32, rdy32, en8, dat8, busy8, done8, err8, rdy8};
    n_checks++;
    if (got !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%b want=%b", got, 12'd0);
    end
    rst = 1'b0; tx_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    got = {en32, dat32, busy32, done32, err32, rdy32, en8, dat8, busy8, done8, err8, rdy8};
    n_checks++;
    if (got !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_priority got=%b want=%b", got, 12'd0);
    end
  endtask

  task automatic test_single_byte();
    int en, hs;
    sel8 = 1'b0; etu = 32;
    do_reset();
    load_frame('{8'h26, 8'h00, 8'h00, 8'h00}, 1, 1'b1);
    run_frame(-1, en, hs);
    check_counts("single_byte", en, 320, hs, 1);
  endtask

  task automatic test_two_bytes();
    int en, hs;
    do_reset();
    load_frame('{8'h93, 8'h20, 8'h00, 8'h00}, 2, 1'b1);
    run_frame(-1, en, hs);
    check_counts("two_bytes", en, 608, hs, 2);
  endtask

  task automatic test_underrun();
    int en, hs;
    do_reset();
    load_frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 1, 1'b0);
    run_frame(-1, en, hs);
    check_counts("underrun_parity", en, 320, hs, 1);
    do_reset();
    load_frame('{8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b0);
    run_frame(-1, en, hs);
    check_counts("underrun_sof", en, 32, hs, 0);
  endtask

  task automatic test_start_ignored();
    int en, hs;
    do_reset();
    load_frame('{8'h26, 8'h00, 8'h00, 8'h00}, 1, 1'b1);
    run_frame(50, en, hs);
    check_counts("start_ignored", en, 320, hs, 1);
  endtask

  task automatic test_reset_mid();
    int en, hs;
    logic [5:0] got;
    do_reset();
    @(negedge clk);
    tx_start = 1'b1; in_valid = 1'b1; in_byte = 8'h26; in_last = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      tx_start = 1'b0;
      rst = (cyc == 100);
      @(posedge clk);
    end
    @(negedge clk);
    got = obs();
    n_checks++;
    if (got !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_mid got=%b want=%b", got, 6'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    got = obs();
    n_checks++;
    if (got !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_no_pulse got=%b want=%b", got, 6'd0);
    end
    load_frame('{8'h26, 8'h00, 8'h00, 8'h00}, 1, 1'b1);
    run_frame(-1, en, hs);
    check_counts("after_reset", en, 320, hs, 1);
  endtask

  task automatic test_back_to_back();
    int en, hs;
    do_reset();
    load_frame('{8'h5A, 8'hFF, 8'h01, 8'h00}, 3, 1'b1);
    run_frame(-1, en, hs);
    check_counts("b2b_first", en, 32 + 3 * 288, hs, 3);
    load_frame('{8'h3C, 8'h00, 8'h00, 8'h00}, 1, 1'b1);
    run_frame(-1, en, hs);
    check_counts("b2b_second", en, 320, hs, 1);
  endtask

  task automatic test_etu8();
    int en, hs;
    sel8 = 1'b1; etu = 8;
    do_reset();
    load_frame('{8'h00, 8'h00, 8'h00, 8'h00}, 1, 1'b1);
    run_frame(-1, en, hs);
    check_counts("etu8", en, 80, hs, 1);
    sel8 = 1'b0; etu = 32;
  endtask

  initial begin
    rst = 1'b1; tx_start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0;
    test_reset();
    test_single_byte();
    test_two_bytes();
    test_underrun();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_etu8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
